// File: rtl/axil_pkg.sv
// Shared constants and types for the AXI4-Lite register access arbiter.
package axil_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    DONE
  } arb_state_e;

  // Register accesses are word-granular; any set low address bit is rejected.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; combinational, last grant is held by the caller.
module rr_arbiter_2
  import axil_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  // Single requester wins outright; on contention the client not served last wins.
  always_comb begin
    gnt_valid_o = enable_i & (|req_i);
    gnt_idx_o   = 1'b0;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_grant_i;
    end else begin
      gnt_idx_o = req_i[1];
    end
  end

endmodule

// File: rtl/axil_reg_access_arbiter.sv
// Arbitrates two request/ack clients onto a single AXI4-Lite master port,
// one transaction in flight at a time, all outputs registered.
module axil_reg_access_arbiter
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,

  input  logic [1:0]                  req_i,
  input  logic [1:0]                  we_i,
  input  logic [2*ADDR_WIDTH-1:0]     addr_i,
  input  logic [2*DATA_WIDTH-1:0]     wdata_i,
  input  logic [2*(DATA_WIDTH/8)-1:0] wstrb_i,
  output logic [1:0]                  ack_o,
  output logic [DATA_WIDTH-1:0]       rdata_o,
  output logic [1:0]                  resp_o,
  output logic                        busy_o,
  output logic                        grant_o,

  output logic [ADDR_WIDTH-1:0]       m_axil_awaddr,
  output logic                        m_axil_awvalid,
  input  logic                        m_axil_awready,
  output logic [DATA_WIDTH-1:0]       m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0]     m_axil_wstrb,
  output logic                        m_axil_wvalid,
  input  logic                        m_axil_wready,
  input  logic [1:0]                  m_axil_bresp,
  input  logic                        m_axil_bvalid,
  output logic                        m_axil_bready,
  output logic [ADDR_WIDTH-1:0]       m_axil_araddr,
  output logic                        m_axil_arvalid,
  input  logic                        m_axil_arready,
  input  logic [DATA_WIDTH-1:0]       m_axil_rdata,
  input  logic [1:0]                  m_axil_rresp,
  input  logic                        m_axil_rvalid,
  output logic                        m_axil_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  arb_state_e              state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    grant_q, grant_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [1:0]              ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;

  logic [1:0]              req_eff;
  logic                    gnt_valid;
  logic                    gnt_idx;
  logic                    cand_we;
  logic [ADDR_WIDTH-1:0]   cand_addr;
  logic [DATA_WIDTH-1:0]   cand_wdata;
  logic [STRB_WIDTH-1:0]   cand_wstrb;
  logic                    aw_hs;
  logic                    w_hs;

  // The ack is visible during the IDLE cycle that also arbitrates; the acked
  // client still holds req then, so it is masked to avoid re-granting it.
  assign req_eff = req_i & ~ack_q;
  assign aw_hs   = awvalid_q & m_axil_awready;
  assign w_hs    = wvalid_q & m_axil_wready;

  rr_arbiter_2 u_arb (
    .req_i        (req_eff),
    .last_grant_i (last_grant_q),
    .enable_i     (state_q == IDLE),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  // Select the command slice belonging to the winning client.
  always_comb begin
    cand_we    = we_i[0];
    cand_addr  = addr_i[ADDR_WIDTH-1:0];
    cand_wdata = wdata_i[DATA_WIDTH-1:0];
    cand_wstrb = wstrb_i[STRB_WIDTH-1:0];
    if (gnt_idx) begin
      cand_we    = we_i[1];
      cand_addr  = addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
      cand_wdata = wdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
      cand_wstrb = wstrb_i[2*STRB_WIDTH-1:STRB_WIDTH];
    end
  end

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    resp_d       = resp_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_d      = gnt_idx;
          last_grant_d = gnt_idx;
          we_d         = cand_we;
          addr_d       = cand_addr;
          wdata_d      = cand_wdata;
          wstrb_d      = cand_wstrb;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          rdata_d      = '0;
          resp_d       = OKAY;
          if (is_misaligned(cand_addr[1:0])) begin
            resp_d  = SLVERR;
            state_d = DONE;
          end else if (cand_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end

      WR_AW_W: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end

      WR_B: begin
        if (m_axil_bvalid && bready_q) begin
          resp_d   = m_axil_bresp;
          bready_d = 1'b0;
          state_d  = DONE;
        end
      end

      RD_AR: begin
        if (arvalid_q && m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end

      RD_R: begin
        if (m_axil_rvalid && rready_q) begin
          rdata_d  = m_axil_rdata;
          resp_d   = m_axil_rresp;
          rready_d = 1'b0;
          state_d  = DONE;
        end
      end

      DONE: begin
        ack_d[grant_q] = 1'b1;
        state_d        = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
    end
  end

  assign ack_o          = ack_q;
  assign rdata_o        = rdata_q;
  assign resp_o         = resp_q;
  assign busy_o         = (state_q != IDLE);
  assign grant_o        = grant_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

  // we_q is carried for completeness of the latched command.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_axil_reg_access_arbiter.sv
// Directed bench for axil_reg_access_arbiter with a small AXI4-Lite register slave.
module tb_axil_reg_access_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [1:0]        req_i = '0;
  logic [1:0]        we_i = '0;
  logic [2*AW-1:0]   addr_i = '0;
  logic [2*DW-1:0]   wdata_i = '0;
  logic [2*SW-1:0]   wstrb_i = '0;
  logic [1:0]        ack_o;
  logic [DW-1:0]     rdata_o;
  logic [1:0]        resp_o;
  logic              busy_o;
  logic              grant_o;
  logic [AW-1:0]     awaddr;
  logic              awvalid, awready;
  logic [DW-1:0]     wdata;
  logic [SW-1:0]     wstrb;
  logic              wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic [AW-1:0]     araddr;
  logic              arvalid, arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid, rready;

  axil_reg_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .ack_o(ack_o), .rdata_o(rdata_o), .resp_o(resp_o), .busy_o(busy_o), .grant_o(grant_o),
    .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  always #5 ACLK = ~ACLK;

  // ---------------- slave model ----------------
  logic [31:0] mem [16];
  int          aw_lat = 0;
  int          aw_cnt = 0;
  bit          b_hold = 0;
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d;
  logic [3:0]  w_s;
  int          cyc = 0;
  int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, write_cnt = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0;

  assign awready = (aw_cnt >= aw_lat);
  assign wready  = 1'b1;
  assign arready = 1'b1;
  assign bresp   = 2'b00;
  assign rresp   = 2'b00;

  always @(posedge ACLK) begin
    logic        hs_aw, hs_w, have_aw, have_w;
    logic [31:0] a, d, tmp;
    logic [3:0]  s;
    cyc <= cyc + 1;
    if (ARESET) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      rdata <= '0; aw_cnt <= 0; aw_a <= '0; w_d <= '0; w_s <= '0;
    end else begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1; else aw_cnt <= 0;
      if (hs_aw) begin aw_got <= 1'b1; aw_a <= awaddr; aw_hs_n <= aw_hs_n + 1; aw_hs_cyc <= cyc; end
      if (hs_w)  begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; w_hs_n <= w_hs_n + 1; w_hs_cyc <= cyc; end
      have_aw = aw_got | hs_aw;
      have_w  = w_got | hs_w;
      a = aw_got ? aw_a : awaddr;
      d = w_got ? w_d : wdata;
      s = w_got ? w_s : wstrb;
      if (bvalid && bready) begin bvalid <= 1'b0; b_hs_cyc <= cyc; end
      if (have_aw && have_w && !bvalid && !b_hold) begin
        tmp = mem[a[5:2]];
        for (int b = 0; b < 4; b++) if (s[b]) tmp[8*b +: 8] = d[8*b +: 8];
        mem[a[5:2]] <= tmp;
        write_cnt <= write_cnt + 1;
        bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid  <= 1'b1;
        rdata   <= mem[araddr[5:2]];
        ar_hs_n <= ar_hs_n + 1;
      end
    end
  end

  // ---------------- protocol monitor (pre-edge values) ----------------
  logic p_aw = 0, p_awr = 0, p_w = 0, p_wr = 0, p_ar = 0, p_arr = 0, p_rst = 1;
  int   viol = 0;
  int   valid_seen = 0;
  always @(posedge ACLK) begin
    if (!p_rst && ((p_aw && !p_awr && !awvalid) || (p_w && !p_wr && !wvalid) ||
                   (p_ar && !p_arr && !arvalid)))
      viol = viol + 1;
    if (!ARESET && (awvalid || wvalid || arvalid)) valid_seen = valid_seen + 1;
    p_aw = awvalid; p_awr = awready; p_w = wvalid; p_wr = wready;
    p_ar = arvalid; p_arr = arready; p_rst = ARESET;
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    req_i = '0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic run_txn(input int c, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st,
                         output logic [31:0] rd, output logic [1:0] rs,
                         output logic [1:0] ackv, output int lat, output logic [2:0] v1);
    @(negedge ACLK);
    we_i[c] = we;
    addr_i[c*AW +: AW] = addr;
    wdata_i[c*DW +: DW] = wd;
    wstrb_i[c*SW +: SW] = st;
    req_i[c] = 1'b1;
    lat = 0; ackv = '0; rd = '0; rs = '0; v1 = '0;
    while (lat < 60 && ackv == 2'b00) begin
      @(negedge ACLK);
      lat++;
      if (lat == 1) v1 = {awvalid, wvalid, arvalid};
      if (ack_o != 2'b00) begin
        ackv = ack_o; rd = rdata_o; rs = resp_o;
      end
    end
    req_i[c] = 1'b0;
    @(negedge ACLK);
    chk($sformatf("ack_pulse_c%0d", c), 64'(ack_o), 64'd0);
  endtask

  typedef struct {
    int          c;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
    logic [1:0]  exp_ack;
    int          exp_lat;
    logic [2:0]  exp_v1;
    int          exp_aw;
    int          exp_w;
    int          exp_ar;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs, ak;
    logic [2:0]  v1;
    int          lat, aw0, w0, ar0, vs0, wc0, n, ack_cyc, acks;
    int          ord[4];
    bit          reached, got;

    vecs[0] = '{0, 1'b1, 32'h004, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        2'b00, 2'b01, 4, 3'b110, 1, 1, 0};
    vecs[1] = '{0, 1'b0, 32'h004, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 2'b00, 2'b01, 4, 3'b001, 0, 0, 1};
    vecs[2] = '{1, 1'b0, 32'h006, 32'h0,        4'h0, 1'b1, 32'h0,        2'b10, 2'b10, 2, 3'b000, 0, 0, 0};
    vecs[3] = '{1, 1'b1, 32'h004, 32'h12345678, 4'h3, 1'b0, 32'h0,        2'b00, 2'b10, 4, 3'b110, 1, 1, 0};
    vecs[4] = '{0, 1'b0, 32'h004, 32'h0,        4'h0, 1'b1, 32'hDEAD5678, 2'b00, 2'b01, 4, 3'b001, 0, 0, 1};
    vecs[5] = '{1, 1'b1, 32'h00B, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,        2'b10, 2'b10, 2, 3'b000, 0, 0, 0};
    vecs[6] = '{1, 1'b0, 32'h03C, 32'h0,        4'h0, 1'b1, 32'h0,        2'b00, 2'b10, 4, 3'b001, 0, 0, 1};

    // Reset state
    apply_reset();
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_busy_grant", 64'({busy_o, grant_o}), 64'd0);
    chk("rst_rdata_resp", 64'({rdata_o, resp_o}), 64'd0);
    chk("rst_handshake", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("rst_addr_data", 64'({awaddr, araddr} | 64'(wdata) | 64'(wstrb)), 64'd0);

    // Single-client table
    for (int i = 0; i < 7; i++) begin
      aw0 = aw_hs_n; w0 = w_hs_n; ar0 = ar_hs_n; vs0 = valid_seen;
      run_txn(vecs[i].c, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, rs, ak, lat, v1);
      chk($sformatf("v%0d_ack", i), 64'(ak), 64'(vecs[i].exp_ack));
      chk($sformatf("v%0d_resp", i), 64'(rs), 64'(vecs[i].exp_resp));
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_valid_at_1", i), 64'(v1), 64'(vecs[i].exp_v1));
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      chk($sformatf("v%0d_aw_hs", i), 64'(aw_hs_n - aw0), 64'(vecs[i].exp_aw));
      chk($sformatf("v%0d_w_hs", i), 64'(w_hs_n - w0), 64'(vecs[i].exp_w));
      chk($sformatf("v%0d_ar_hs", i), 64'(ar_hs_n - ar0), 64'(vecs[i].exp_ar));
      if (vecs[i].exp_aw + vecs[i].exp_w + vecs[i].exp_ar == 0)
        chk($sformatf("v%0d_no_valid", i), 64'(valid_seen - vs0), 64'd0);
    end

    // Simultaneous writes right after reset: client 0 first
    apply_reset();
    @(negedge ACLK);
    we_i = 2'b11;
    addr_i = {32'h008, 32'h000};
    wdata_i = {32'h22, 32'h11};
    wstrb_i = 8'hFF;
    req_i = 2'b11;
    n = 0;
    for (int i = 0; i < 4; i++) ord[i] = -1;
    for (int t = 0; t < 60 && n < 2; t++) begin
      @(negedge ACLK);
      if (ack_o[0]) begin ord[n] = 0; n++; req_i[0] = 1'b0; end
      if (ack_o[1]) begin ord[n] = 1; n++; req_i[1] = 1'b0; end
    end
    req_i = '0;
    chk("dual_ack_count", 64'(n), 64'd2);
    chk("dual_first", 64'(ord[0]), 64'd0);
    chk("dual_second", 64'(ord[1]), 64'd1);
    run_txn(0, 1'b0, 32'h000, 32'h0, 4'h0, rd, rs, ak, lat, v1);
    chk("dual_rb0", 64'(rd), 64'h11);
    run_txn(0, 1'b0, 32'h008, 32'h0, 4'h0, rd, rs, ak, lat, v1);
    chk("dual_rb8", 64'(rd), 64'h22);

    // Continuous reads from both clients: grants alternate
    apply_reset();
    @(negedge ACLK);
    we_i = 2'b00;
    addr_i = {32'h008, 32'h000};
    req_i = 2'b11;
    n = 0;
    for (int i = 0; i < 4; i++) ord[i] = -1;
    for (int t = 0; t < 80 && n < 4; t++) begin
      @(negedge ACLK);
      if (ack_o[0]) begin ord[n] = 0; n++; end
      else if (ack_o[1]) begin ord[n] = 1; n++; end
    end
    req_i = '0;
    chk("rr_ack_count", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 64'(ord[i]), 64'(i % 2));
    for (int t = 0; t < 20 && (busy_o || ack_o != 2'b00); t++) @(negedge ACLK);

    // W handshake three cycles before AW
    aw_lat = 3;
    wc0 = write_cnt;
    @(negedge ACLK);
    we_i[0] = 1'b1;
    addr_i[31:0] = 32'h00C;
    wdata_i[31:0] = 32'hA5A5A5A5;
    wstrb_i[3:0] = 4'hF;
    req_i[0] = 1'b1;
    lat = 0; got = 0; ack_cyc = 0;
    while (lat < 60 && !got) begin
      @(negedge ACLK);
      lat++;
      if (lat == 2) chk("wfirst_valids_c2", 64'({awvalid, wvalid}), 64'b10);
      if (lat == 4) chk("wfirst_valids_c4", 64'({awvalid, wvalid}), 64'b10);
      if (ack_o[0]) begin got = 1; ack_cyc = cyc; end
    end
    req_i[0] = 1'b0;
    chk("wfirst_lat", 64'(lat), 64'd7);
    chk("wfirst_hs_gap", 64'(aw_hs_cyc - w_hs_cyc), 64'd3);
    chk("wfirst_one_write", 64'(write_cnt - wc0), 64'd1);
    chk("wfirst_ack_after_b", 64'(ack_cyc > b_hs_cyc), 64'd1);
    aw_lat = 0;
    run_txn(0, 1'b0, 32'h00C, 32'h0, 4'h0, rd, rs, ak, lat, v1);
    chk("wfirst_rb", 64'(rd), 64'hA5A5A5A5);

    // Reset while waiting in WR_B
    b_hold = 1;
    @(negedge ACLK);
    we_i[1] = 1'b1;
    addr_i[63:32] = 32'h000;
    wdata_i[63:32] = 32'h55;
    wstrb_i[7:4] = 4'hF;
    req_i[1] = 1'b1;
    reached = 0;
    for (int t = 0; t < 20 && !reached; t++) begin
      @(negedge ACLK);
      if (bready && busy_o) reached = 1;
    end
    chk("wrb_reached", 64'(reached), 64'd1);
    ARESET = 1'b1;
    req_i = '0;
    @(negedge ACLK);
    chk("wrb_rst_handshake", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("wrb_rst_busy", 64'(busy_o), 64'd0);
    chk("wrb_rst_ack", 64'(ack_o), 64'd0);
    b_hold = 0;
    ARESET = 1'b0;
    acks = 0;
    repeat (5) begin
      @(negedge ACLK);
      if (ack_o != 2'b00) acks++;
    end
    chk("wrb_no_ack", 64'(acks), 64'd0);
    run_txn(0, 1'b0, 32'h000, 32'h0, 4'h0, rd, rs, ak, lat, v1);
    chk("wrb_fresh_rdata", 64'(rd), 64'd0);
    chk("wrb_fresh_resp", 64'(rs), 64'd0);
    chk("wrb_fresh_ack", 64'(ak), 64'b01);

    chk("valid_stable", 64'(viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/axil_reg_access_arbiter.md
Name: axil_reg_access_arbiter

Overview:
- Shares one AXI4-Lite slave register file between two simple request/acknowledge clients, for example a host bridge and an internal config sequencer.
- Arbitrates round-robin, latches the winner's command and drives the full AXI4-Lite master channel set.
- Returns read data and response to the granted client with a one-cycle ack pulse.
- Exactly one AXI transaction is in flight at any time.

Parameters:
- ADDR_WIDTH, 32, address width of the client ports and the AXI-Lite port.
- DATA_WIDTH, 32, data width; the strobe width is DATA_WIDTH/8.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- req_i  in  2  per-client request; held until that client's ack.
- we_i  in  2  per-client write enable (1 = write, 0 = read).
- addr_i  in  2*ADDR_WIDTH  per-client address; client k uses slice k.
- wdata_i  in  2*DATA_WIDTH  per-client write data.
- wstrb_i  in  2*DATA_WIDTH/8  per-client write strobes.
- ack_o  out  2  one-cycle completion pulse per client.
- rdata_o  out  DATA_WIDTH  read data, valid while ack_o is nonzero.
- resp_o  out  2  AXI response code, valid while ack_o is nonzero.
- busy_o  out  1  high whenever the state is not IDLE.
- grant_o  out  1  index of the granted client, valid while busy_o is high.
- m_axil_awaddr / awvalid / awready  out / out / in  ADDR_WIDTH / 1 / 1  write address channel.
- m_axil_wdata / wstrb / wvalid / wready  out / out / out / in  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  write data channel.
- m_axil_bresp / bvalid / bready  in / in / out  2 / 1 / 1  write response channel.
- m_axil_araddr / arvalid / arready  out / out / in  ADDR_WIDTH / 1 / 1  read address channel.
- m_axil_rdata / rresp / rvalid / rready  in / in / in / out  DATA_WIDTH / 2 / 1 / 1  read data channel.

Behaviour:
- Reset values (ARESET=1 at a rising edge):
  - state = IDLE, last_grant = 1.
  - All valid/ready outputs 0, ack_o = 0, busy_o = 0, grant_o = 0, rdata_o = 0, resp_o = 0.
  - Address and data outputs = 0.
  - Reset mid-transaction takes effect at the next edge regardless of state. The slave is reset by the same ARESET.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Arbitration happens only in IDLE:
  - One requester active: that client is granted.
  - Both active: grant goes to the client other than last_grant.
  - On grant: latch we, addr, wdata and wstrb from the winning slice; update last_grant and grant_o.
- Misaligned address (addr[1:0] != 0): no AXI traffic is issued. The FSM goes to DONE with resp = 2'b10 (SLVERR) and rdata = 0.
- State machine:
  - IDLE -> WR_AW_W when the grant is a write. awvalid and wvalid both rise in the next cycle.
  - IDLE -> RD_AR when the grant is a read. arvalid rises in the next cycle.
  - WR_AW_W:
    - awvalid drops on its own handshake edge (awvalid & awready).
    - wvalid drops on its own handshake edge (wvalid & wready).
    - The handshakes may occur in either order or on the same edge; completion is tracked with aw_done and w_done flags.
    - Once both are done -> WR_B, with bready = 1.
    - A valid, once asserted, is never deasserted before its handshake.
  - WR_B: on bvalid & bready, capture bresp into resp_o, drop bready -> DONE.
  - RD_AR: arvalid held until arvalid & arready; then drop it, set rready = 1 -> RD_R.
  - RD_R: on rvalid & rready, capture rdata and rresp, drop rready -> DONE.
  - DONE: ack_o[grant] = 1 for exactly one cycle, then back to IDLE. The next arbitration happens in that IDLE cycle.
- Client rules:
  - A client drops req on the edge where it samples its ack.
  - A req dropped before ack does not abort the transaction; the ack is still issued.
  - A client whose req is low is never granted.
- Minimum latency, with the slave ready immediately (all counted from the req edge):
  - Read: arvalid at +1, ack at +4.
  - Write: aw/w valid at +1, ack at +4 (+5 if the slave asserts bvalid one cycle after the W handshake).
- No timeout: a stalled slave holds the FSM indefinitely, because AXI forbids withdrawing valid.

Decomposition:
- Package axil_pkg:
  - AXI response constants: OKAY = 2'b00, SLVERR = 2'b10.
  - 3-bit typedef arb_state_e: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE.
- Sub-module rr_arbiter_2:
  - Inputs: req[1:0], last_grant, enable.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational; the top level registers last_grant.

Test Plan:
- Client 0 writes 0xDEADBEEF to 0x004 with wstrb = 0xF, then client 0 reads 0x004 -> two acks on client 0, both resp = 00, rdata = 0xDEADBEEF; one AW, one W and one AR handshake each.
- Both clients request on the same edge right after reset: client 0 writes 0x11 to 0x000, client 1 writes 0x22 to 0x008 -> client 0 is granted first and acked first. Readback gives 0x11 at 0x000 and 0x22 at 0x008.
- Both clients request reads continuously for four transactions -> grants alternate 0,1,0,1; the never-granted count for each client is at most 1.
- Slave asserts wready 3 cycles before awready -> wvalid drops first and awvalid stays high until its own handshake. Exactly one register write occurs and ack arrives after bvalid.
- Client 1 issues a read of address 0x006 -> no AXI valid is asserted; ack_o = 2'b10, resp_o = 2'b10, rdata_o = 0.
- Assert ARESET while in WR_B -> at the next edge all valids and readies are 0, busy_o = 0 and no ack is issued. A fresh read of 0x000 afterwards returns 0x0 with resp 00.
